// File: rtl/sfu_acc_array.sv
// sfu_acc_array: per-channel banks of saturating accumulators
// drained in address order over a valid/ready stream with optional ReLU.
module sfu_acc_array #(
  parameter int col       = 8,
  parameter int psum_bw   = 16,
  parameter int acc_depth = 16,
  parameter int addr_bw   = $clog2(acc_depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [addr_bw-1:0]     in_addr,
  input  logic                   in_clear,
  input  logic [col*psum_bw-1:0] sfu_in,
  input  logic                   relu,
  input  logic                   drain_start,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [addr_bw-1:0]     out_addr,
  output logic [col*psum_bw-1:0] sfu_out,
  output logic                   drain_done
);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  localparam logic [addr_bw-1:0] LAST =
    addr_bw'(acc_depth - 1);

  localparam logic signed [psum_bw-1:0] PMAX =
    {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] PMIN =
    {1'b1, {(psum_bw-1){1'b0}}};

  logic [0:0]             state_q, state_d;
  // extra MSB marks "every entry already loaded"
  logic [addr_bw:0]       ptr_q, ptr_d;
  logic                   relu_q, relu_d;
  logic                   out_valid_q, out_valid_d;
  logic [addr_bw-1:0]     out_addr_q, out_addr_d;
  logic [col*psum_bw-1:0] sfu_out_q, sfu_out_d;
  logic                   drain_done_q, drain_done_d;

  logic signed [psum_bw-1:0] acc_q [col][acc_depth];

  logic signed [psum_bw:0]   sum_w  [col];
  logic signed [psum_bw-1:0] wr_val [col];
  logic [col*psum_bw-1:0]    rd_vec;
  logic [addr_bw-1:0]        rd_idx;

  logic in_fire;
  logic out_fire;
  logic load;

  assign in_ready = (state_q == S_ACCUM);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign rd_idx   = ptr_q[addr_bw-1:0];

  // a slot opens when the output register is empty or being consumed
  assign load = (state_q == S_DRAIN) && !ptr_q[addr_bw]
             && (!out_valid_q || out_fire);

  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign sfu_out    = sfu_out_q;
  assign drain_done = drain_done_q;

  // per-channel write value: overwrite or saturating add
  always_comb begin
    for (int c = 0; c < col; c++) begin
      sum_w[c] =
        {acc_q[c][in_addr][psum_bw-1], acc_q[c][in_addr]}
        + {sfu_in[c*psum_bw+psum_bw-1],
           sfu_in[c*psum_bw +: psum_bw]};
      if (in_clear)
        wr_val[c] = sfu_in[c*psum_bw +: psum_bw];
      else if (sum_w[c][psum_bw] != sum_w[c][psum_bw-1])
        wr_val[c] = sum_w[c][psum_bw] ? PMIN : PMAX;
      else
        wr_val[c] = sum_w[c][psum_bw-1:0];
    end
  end

  // drain read of the next entry with optional ReLU
  always_comb begin
    rd_vec = '0;
    for (int c = 0; c < col; c++) begin
      if (relu_q && acc_q[c][rd_idx][psum_bw-1])
        rd_vec[c*psum_bw +: psum_bw] = '0;
      else
        rd_vec[c*psum_bw +: psum_bw] = acc_q[c][rd_idx];
    end
  end

  // control next-state: mode FSM, drain pointer, output register
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    relu_d       = relu_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    sfu_out_d    = sfu_out_q;
    drain_done_d = 1'b0;
    unique case (state_q)
      S_ACCUM: begin
        if (drain_start) begin
          state_d = S_DRAIN;
          relu_d  = relu;
          ptr_d   = '0;
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          if (out_addr_q == LAST) begin
            drain_done_d = 1'b1;
            state_d      = S_ACCUM;
          end
        end
        if (load) begin
          out_valid_d = 1'b1;
          out_addr_d  = rd_idx;
          sfu_out_d   = rd_vec;
          ptr_d       = ptr_q + 1'b1;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  // control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_ACCUM;
      ptr_q        <= '0;
      relu_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      sfu_out_q    <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      relu_q       <= relu_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      sfu_out_q    <= sfu_out_d;
      drain_done_q <= drain_done_d;
    end
  end

  // accumulator banks: accumulate in ACCUM, clear on drained beat
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++)
        for (int e = 0; e < acc_depth; e++)
          acc_q[c][e] <= '0;
    end else begin
      if (in_fire)
        for (int c = 0; c < col; c++)
          acc_q[c][in_addr] <= wr_val[c];
      if (out_fire)
        for (int c = 0; c < col; c++)
          acc_q[c][out_addr_q] <= '0;
    end
  end

endmodule

// File: tb/tb_sfu_acc_array.sv
// tb_sfu_acc_array: table vectors, corner sequences and random
// traffic checked against an integer model of the accumulators.
module tb_sfu_acc_array;

  localparam int C  = 8;
  localparam int PB = 16;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int W  = C * PB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic          in_clear = 1'b0;
  logic [W-1:0]  sfu_in = '0;
  logic          relu = 1'b0;
  logic          drain_start = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [W-1:0]  sfu_out;
  logic          drain_done;

  sfu_acc_array #(
    .col(C), .psum_bw(PB), .acc_depth(D)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_clear(in_clear),
    .sfu_in(sfu_in), .relu(relu),
    .drain_start(drain_start),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .sfu_out(sfu_out),
    .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int model [C][D];
  int exp_m [C][D];

  typedef struct {
    int addr;
    bit clr;
    int v [C];
    int e [C];
  } vec_t;

  vec_t tbl [7];

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < C; c++)
      for (int a = 0; a < D; a++)
        model[c][a] = 0;
  endtask

  task automatic wr(input int a, input bit clr, input int v [C]);
    chk("wr_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_addr  = AW'(a);
    in_clear = clr;
    for (int c = 0; c < C; c++) begin
      sfu_in[c*PB +: PB] = PB'(v[c]);
      model[c][a] = clr ? v[c] : sat(model[c][a] + v[c]);
    end
    step();
    in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: 4-cycle stall at entry 2
  task automatic drain(input bit r, input int mode, input bit simul);
    int idx;
    int cyc;
    int stall;
    bit prev_stall;
    bit rdy;
    logic [W-1:0]  prev_out;
    logic [AW-1:0] prev_addr;
    logic [W-1:0]  ev;
    int v;
    drain_start = 1'b1;
    relu        = r;
    if (simul) begin
      in_valid = 1'b1;
      in_addr  = '0;
      in_clear = 1'b0;
      for (int c = 0; c < C; c++) sfu_in[c*PB +: PB] = 16'd5;
    end
    step();
    drain_start = 1'b0;
    relu        = ~r;
    if (simul)
      for (int c = 0; c < C; c++) sfu_in[c*PB +: PB] = 16'd99;
    step();
    chk("start_out_valid", out_valid, 1);
    chk("start_out_addr", out_addr, 0);
    chk("start_in_ready", in_ready, 0);
    idx = 0; cyc = 0; stall = 0; prev_stall = 0;
    prev_out = '0; prev_addr = '0;
    while (idx < D && cyc < 400) begin
      if (prev_stall) begin
        chk("bp_valid", out_valid, 1);
        chk("bp_addr", out_addr, prev_addr);
        chkv("bp_data", sfu_out, prev_out);
      end
      drain_start = (simul && cyc == 0);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = !(idx == 2 && stall < 4);
          if (!rdy) stall++;
        end
      endcase
      out_ready = rdy;
      if (mode == 0) chk("no_bubble", out_valid, 1);
      if (out_valid && rdy) begin
        for (int c = 0; c < C; c++) begin
          v = exp_m[c][idx];
          if (r && v < 0) v = 0;
          ev[c*PB +: PB] = PB'(v);
        end
        chk($sformatf("beat%0d_addr", idx), out_addr, idx);
        chkv($sformatf("beat%0d_data", idx), sfu_out, ev);
        idx++;
      end
      prev_stall = out_valid && !rdy;
      prev_out   = sfu_out;
      prev_addr  = out_addr;
      step();
      cyc++;
    end
    in_valid    = 1'b0;
    drain_start = 1'b0;
    out_ready   = 1'b0;
    chk("beats_seen", idx, D);
    if (mode == 2) chk("stall_cycles", stall, 4);
    chk("done_pulse", drain_done, 1);
    chk("done_in_ready", in_ready, 1);
    chk("done_out_valid", out_valid, 0);
    step();
    chk("done_drop", drain_done, 0);
    clear_model();
  endtask

  task automatic load_tbl_exp();
    for (int c = 0; c < C; c++)
      for (int a = 0; a < D; a++)
        exp_m[c][a] = 0;
    for (int i = 0; i < 7; i++)
      for (int c = 0; c < C; c++)
        exp_m[c][tbl[i].addr] = tbl[i].e[c];
  endtask

  task automatic apply_tbl();
    for (int i = 0; i < 7; i++)
      wr(tbl[i].addr, tbl[i].clr, tbl[i].v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int vals [C];
    int cnt;
    int cyc;

    tbl[0] = '{addr: 3, clr: 1'b1,
               v: '{default: 100}, e: '{default: 100}};
    tbl[1] = '{addr: 3, clr: 1'b0,
               v: '{default: 23}, e: '{default: 123}};
    tbl[2] = '{addr: 0, clr: 1'b1,
               v: '{32000, -32000, 0, 0, 0, 0, 0, 0},
               e: '{32000, -32000, 0, 0, 0, 0, 0, 0}};
    tbl[3] = '{addr: 0, clr: 1'b0,
               v: '{1000, -1000, 0, 0, 0, 0, 0, 0},
               e: '{32767, -32768, 0, 0, 0, 0, 0, 0}};
    tbl[4] = '{addr: 5, clr: 1'b1,
               v: '{0, 0, -7, 7, 0, 0, 0, 0},
               e: '{0, 0, -7, 7, 0, 0, 0, 0}};
    tbl[5] = '{addr: 15, clr: 1'b1,
               v: '{-32768, 32767, 1, -1, 0, 0, 0, 0},
               e: '{-32768, 32767, 1, -1, 0, 0, 0, 0}};
    tbl[6] = '{addr: 15, clr: 1'b0,
               v: '{-1, 1, -5, 5, 0, 0, 0, 0},
               e: '{-32768, 32767, -4, 4, 0, 0, 0, 0}};

    clear_model();
    step();
    step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chkv("rst_sfu_out", sfu_out, '0);
    chk("rst_drain_done", drain_done, 0);

    apply_tbl();
    load_tbl_exp();
    drain(1'b0, 0, 1'b0);

    apply_tbl();
    load_tbl_exp();
    drain(1'b1, 2, 1'b0);

    vals = '{default: 10};
    wr(0, 1'b1, vals);
    for (int c = 0; c < C; c++)
      for (int a = 0; a < D; a++)
        exp_m[c][a] = (a == 0) ? 15 : 0;
    drain(1'b0, 0, 1'b1);
    for (int c = 0; c < C; c++)
      for (int a = 0; a < D; a++)
        exp_m[c][a] = 0;
    drain(1'b0, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < C; c++) vals[c] = 1000 * (i + c + 1);
      wr(i, 1'b1, vals);
    end
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    out_ready   = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 8 && cyc < 100) begin
      if (out_valid && out_ready) cnt++;
      step();
      cyc++;
    end
    chk("mid_beats", cnt, 8);
    reset = 1'b1;
    out_ready = 1'b0;
    step();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    reset = 1'b0;
    step();
    clear_model();
    for (int c = 0; c < C; c++)
      for (int a = 0; a < D; a++)
        exp_m[c][a] = 0;
    drain(1'b0, 0, 1'b0);

    for (int round = 0; round < 4; round++) begin
      for (int n = 0; n < 40; n++) begin
        for (int c = 0; c < C; c++)
          vals[c] = int'($urandom_range(0, 65535)) - 32768;
        wr((n % 3 == 0) ? int'($urandom_range(0, 3))
                        : int'($urandom_range(0, D - 1)),
           ($urandom_range(0, 3) == 0), vals);
      end
      exp_m = model;
      drain(1'($urandom_range(0, 1)), 1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfu_acc_array.md
# sfu_acc_array

Parametrised post-processing array that sits after the MAC array's partial-sum output. Each of `col` channels owns an `acc_depth`-entry bank of signed, saturating accumulators, addressed per transaction. A drain sequence streams every entry out in address order, with optional ReLU, over a valid/ready handshake. This replaces single-register accumulate/ReLU columns with multi-output-row buffering and back-pressure.

## Interface
- `col`, default 8: number of channels, one per MAC column.
- `psum_bw`, default 16: signed partial-sum width per channel.
- `acc_depth`, default 16: accumulator entries per channel; must be a power of two and at least 2.
- `addr_bw`, default `$clog2(acc_depth)`: entry address width.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: the input beat is valid.
- `in_ready` output 1: the array accepts input beats.
- `in_addr` input `addr_bw`: target entry for the beat.
- `in_clear` input 1: overwrite the entry instead of accumulating into it.
- `sfu_in` input `col*psum_bw`: channel i occupies bits `[(i+1)*psum_bw-1 : i*psum_bw]`.
- `relu` input 1: ReLU enable, sampled on the `drain_start` cycle.
- `drain_start` input 1: single-cycle request to drain all entries.
- `out_valid` output 1: `sfu_out` and `out_addr` are valid.
- `out_ready` input 1: the consumer accepts the output beat.
- `out_addr` output `addr_bw`: entry index of the current output beat.
- `sfu_out` output `col*psum_bw`: drained values, packed the same way as `sfu_in`.
- `drain_done` output 1: one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: ACCUM (reset state) and DRAIN.
- ACCUM:
  - `in_ready`=1.
  - A beat is accepted when `in_valid` and `in_ready` are both high.
  - For every channel c, the entry is updated as `acc[c][in_addr] <= in_clear ? sfu_in[c] : sat(acc[c][in_addr] + sfu_in[c])`.
- Arithmetic:
  - Two's-complement addition at `psum_bw+1` bits.
  - Results above 2^(psum_bw-1)-1 clamp to that value; results below -2^(psum_bw-1) clamp to that value.
  - Channels saturate independently.
- `drain_start` in ACCUM:
  - Latches the `relu` mode and moves the FSM to DRAIN next cycle.
  - If a beat is accepted in the same cycle, the write completes before the drain reads that entry.
- `drain_start` in DRAIN is ignored.
- DRAIN:
  - `in_ready`=0.
  - Entries stream out in order 0 … `acc_depth`-1, one per handshake (`out_valid` && `out_ready`).
  - Output value per channel: if the latched relu is set and the value is negative, output 0; otherwise output the value unchanged.
  - Each entry is cleared to 0 on the cycle its beat is accepted.
- Back-pressure: while `out_valid`=1 and `out_ready`=0, `sfu_out` and `out_addr` hold stable.
- End of drain: after the beat for entry `acc_depth`-1 is accepted, `drain_done` pulses for one cycle (the following cycle) and the FSM returns to ACCUM in that same cycle.
- `reset` in any state, including mid-drain:
  - FSM goes to ACCUM.
  - All accumulators are cleared to 0.
  - Drain pointer and latched relu are cleared to 0.
  - Any partially drained sequence is abandoned.

## Timing
- Reset values:
  - `in_ready`=1 from the first cycle after reset.
  - `out_valid`=0, `out_addr`=0, `sfu_out`=0, `drain_done`=0.
- Accumulate: a beat accepted at edge t is visible in the entry after edge t. Back-to-back beats to the same address every cycle are legal and must accumulate exactly, with no read-after-write hazard.
- Drain latency:
  - `drain_start` high at edge t: `in_ready`=0 and `out_valid`=1 with entry 0 after edge t+1.
  - With `out_ready` held at 1, the drain takes `acc_depth` cycles at one entry per cycle, with no bubbles.
  - `drain_done` is high for the cycle after the final handshake; `in_ready`=1 again in that same cycle.
- `sfu_out` is registered: there is no combinational path from `sfu_in` or `out_ready` to `sfu_out`.

## Test plan
- Accumulate then drain:
  - Stimulus: `col`=8, `psum_bw`=16. Write addr 3 with `in_clear`=1 and all channels 100, then `in_clear`=0 with all channels 23. Drain with `relu`=0 and `out_ready`=1.
  - Required: beat for `out_addr`=3 carries 123 on all channels; every other beat carries 0; `drain_done` pulses one cycle after beat 15.
- Saturation:
  - Stimulus: write addr 0 with `in_clear`=1 and value 32000, then add 1000 on channel 0. Separately, write channel 1 with -32000 and add -1000.
  - Required: channel 0 drains 32767; channel 1 drains -32768.
- ReLU:
  - Stimulus: entry 5 holds -7 on channel 2 and +7 on channel 3. Drain with `relu`=1, then deassert `relu` during the drain.
  - Required: drained values are 0 and 7. Repeat with `relu`=0: drained values are -7 and 7.
- Back-pressure:
  - Stimulus: during a drain, hold `out_ready`=0 for 4 cycles at entry 2.
  - Required: `out_valid`=1 and `sfu_out`/`out_addr` are stable for all 4 cycles; no entry is skipped or repeated; total 16 beats.
- Simultaneous events:
  - Stimulus: assert `drain_start` together with an accepted write adding 5 to addr 0, which holds 10.
  - Required: beat 0 carries 15. `in_valid` during DRAIN is not accepted. A second `drain_start` during DRAIN has no effect.
- Reset mid-drain:
  - Stimulus: assert `reset` after beat 7 of a drain.
  - Required: next cycle `out_valid`=0, `in_ready`=1. A subsequent drain outputs 0 for all 16 entries.
